// File: rtl/game_pkg.sv
// Shared scan-code constants, controller-byte list, parser states and key-state bundle
// for the PS/2 key decoder.
package game_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_ARR_L = 8'h6B;
  localparam logic [7:0] SC_ARR_R = 8'h74;
  localparam logic [7:0] SC_ARR_U = 8'h75;
  localparam logic [7:0] SC_ARR_D = 8'h72;

  // Keyboard controller responses; never part of a make/break sequence.
  localparam int NUM_CTRL = 5;
  localparam logic [NUM_CTRL-1:0][7:0] SC_CTRL = {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic [1:0] left;
    logic [1:0] right;
    logic [1:0] jump;
    logic [1:0] stay;
  } keys_t;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_CTRL; i++)
      if (b == SC_CTRL[i]) hit = 1'b1;
    return hit;
  endfunction
endpackage

// File: rtl/scan_parser.sv
// Set-2 scan-code sequence parser: tracks E0/F0 prefixes, abandons stale prefixes
// after TIMEOUT_CYCLES idle clocks, and flags each completed make/break.
module scan_parser
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  parse_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic          ctrl;

  assign ctrl     = is_ctrl_byte(scan_code);
  assign evt_code = scan_code;
  assign evt_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign evt_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

  // Events are decoded from the current state so the key registers update on the
  // same edge that samples the final byte.
  always_comb begin
    evt_valid = 1'b0;
    if (scan_valid && !ctrl) begin
      case (state_q)
        ST_IDLE, ST_EXT:     evt_valid = (scan_code != SC_EXT) && (scan_code != SC_BRK);
        ST_BRK, ST_EXT_BRK:  evt_valid = (scan_code != SC_BRK);
        default:             evt_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (scan_valid) begin
      cnt_q <= '0;
      if (!ctrl) begin
        case (state_q)
          ST_IDLE: begin
            if (scan_code == SC_EXT)      state_q <= ST_EXT;
            else if (scan_code == SC_BRK) state_q <= ST_BRK;
          end
          ST_EXT: begin
            if (scan_code == SC_BRK)      state_q <= ST_EXT_BRK;
            else if (scan_code != SC_EXT) state_q <= ST_IDLE;
          end
          ST_BRK, ST_EXT_BRK: begin
            if (scan_code != SC_BRK)      state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TMAX) state_q <= ST_IDLE;
      else               cnt_q   <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/key_decoder.sv
// PS/2 set-2 key decoder: held left/right/jump/stay vectors (bit0 letter, bit1 arrow).
// Optional KEY_ANTIGHOST_EN lets only the most recent horizontal direction through.
module key_decoder
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [1:0] left,
  output logic [1:0] right,
  output logic [1:0] jump,
  output logic [1:0] stay
);
  logic       evt_valid, evt_ext, evt_brk;
  logic [7:0] evt_code;
  keys_t      keys_q, keys_d;
  logic       mk_left, mk_right;

  scan_parser #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_parser (
    .clk       (clk),
    .rst       (rst),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_brk   (evt_brk)
  );

  // Plain and extended codes are separate keys; unmapped codes leave keys_d alone.
  always_comb begin
    keys_d   = keys_q;
    mk_left  = 1'b0;
    mk_right = 1'b0;
    if (evt_valid) begin
      case ({evt_ext, evt_code})
        {1'b0, SC_A}:     begin keys_d.left[0]  = !evt_brk; mk_left  = !evt_brk; end
        {1'b1, SC_ARR_L}: begin keys_d.left[1]  = !evt_brk; mk_left  = !evt_brk; end
        {1'b0, SC_D}:     begin keys_d.right[0] = !evt_brk; mk_right = !evt_brk; end
        {1'b1, SC_ARR_R}: begin keys_d.right[1] = !evt_brk; mk_right = !evt_brk; end
        {1'b0, SC_W}:     keys_d.jump[0] = !evt_brk;
        {1'b1, SC_ARR_U}: keys_d.jump[1] = !evt_brk;
        {1'b0, SC_S}:     keys_d.stay[0] = !evt_brk;
        {1'b1, SC_ARR_D}: keys_d.stay[1] = !evt_brk;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) keys_q <= '0;
    else     keys_q <= keys_d;
  end

`ifdef KEY_ANTIGHOST_EN
  logic  dir_q, dir_d;
  keys_t out_q, out_d;

  always_comb begin
    dir_d = dir_q;
    if (mk_left)       dir_d = DIR_LEFT;
    else if (mk_right) dir_d = DIR_RIGHT;
    out_d = keys_d;
    if ((keys_d.left != 2'b00) && (keys_d.right != 2'b00)) begin
      if (dir_d == DIR_LEFT) out_d.right = 2'b00;
      else                   out_d.left  = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= DIR_RIGHT;
      out_q <= '0;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

  assign left  = out_q.left;
  assign right = out_q.right;
  assign jump  = out_q.jump;
  assign stay  = out_q.stay;
`else
  logic unused_mk;
  assign unused_mk = mk_left ^ mk_right;
  assign left  = keys_q.left;
  assign right = keys_q.right;
  assign jump  = keys_q.jump;
  assign stay  = keys_q.stay;
`endif
endmodule

// File: doc/key_decoder.md
# key_decoder

Converts the one-cycle scan-code byte strobes from the PS/2 receiver into held key-state vectors for the player movement controller (`move_ctrl`). It decodes set-2 make and break sequences, including the `E0` extended prefix. Outputs are registered `left`, `right`, `jump` and `stay` vectors: bit 0 is the letter binding and bit 1 is the arrow binding. Any nonzero vector means the action is requested.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: clocks allowed between a prefix byte (`E0`/`F0`) and its following byte before the sequence is abandoned.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, **asynchronous, active-high**.
- `scan_code`  in  8  received byte; valid only while `scan_valid` is high.
- `scan_valid`  in  1  one-cycle strobe, one per received byte; may be high on consecutive cycles.
- `left`  out  2  bit0 = A (`1C`), bit1 = Left arrow (`E0 6B`).
- `right`  out  2  bit0 = D (`23`), bit1 = Right arrow (`E0 74`).
- `jump`  out  2  bit0 = W (`1D`), bit1 = Up arrow (`E0 75`).
- `stay`  out  2  bit0 = S (`1B`), bit1 = Down arrow (`E0 72`).

## Operation
- Parser FSM states and transitions, evaluated only on `scan_valid`:
  - `IDLE`:
    - `E0` goes to `EXT`.
    - `F0` goes to `BRK`.
    - Any other byte is a plain make and the FSM stays in `IDLE`.
  - `EXT`:
    - `F0` goes to `EXT_BRK`.
    - Any other byte is an extended make, then the FSM returns to `IDLE`.
  - `BRK`: any byte is a plain break, then the FSM returns to `IDLE`.
  - `EXT_BRK`: any byte is an extended break, then the FSM returns to `IDLE`.
- Byte rules:
  - A make sets the mapped key bit; a break clears it.
  - Unmapped codes change no key bit but still complete the sequence.
  - Controller bytes `AA`, `FA`, `FE`, `EE` and `E1` are ignored in every state and leave the state unchanged.
  - `E0` received while in `EXT` restarts `EXT`.
  - `F0` received while in `BRK` or `EXT_BRK` is ignored.
- Extended and plain codes are distinct keys: plain `6B` (keypad 4) does not drive `left[1]`.
- Repeated makes from typematic repeat leave the bit set, with no glitch.
- Timeout:
  - The counter clears on every `scan_valid`.
  - It counts while the FSM is in any state other than `IDLE`.
  - Reaching `TIMEOUT_CYCLES - 1` forces the FSM to `IDLE` with no key change.
  - The counter saturates and cannot wrap.
- Reset, including assertion mid-sequence: the FSM goes to `IDLE`, the counter to 0, and every output and key register to `2'b00`.

## Timing
- An output bit updates on the clock edge that samples `scan_valid` with the final byte of its sequence. It is visible one cycle after that strobe.
- Each output is a registered flop, with no combinational path from input to output.
- Back-to-back strobes are each processed; there is no dropped byte and no throughput limit.
- A timeout takes effect on the edge where the counter equals `TIMEOUT_CYCLES - 1`. If `scan_valid` arrives on that same edge, the byte wins and is processed in the current state.

## Configuration
- `KEY_ANTIGHOST_EN` defined:
  - A 1-bit last-direction register records whether a left or a right make occurred most recently.
  - While both the raw left and raw right vectors are nonzero, only the most recent direction is driven; the other output reads `2'b00`.
  - Releasing the winner immediately exposes the other direction if it is still held.
  - The last-direction register resets to "right".
- `KEY_ANTIGHOST_EN` undefined: raw key vectors are driven directly, and `left` and `right` may both be nonzero. `move_ctrl` treats that case as stationary.

## Structure
- `game_pkg` holds:
  - the scan-code localparams: `SC_EXT`, `SC_BRK`, `SC_A`, `SC_D`, `SC_W`, `SC_S`, `SC_ARR_L`, `SC_ARR_R`, `SC_ARR_U`, `SC_ARR_D`;
  - the controller-byte list;
  - the parser state enum.
- Sub-module `scan_parser` contains the FSM and the timeout counter. It emits a one-cycle `evt_valid` together with `evt_code[7:0]`, `evt_ext` and `evt_brk`.
- The top level contains the key-state registers, the binding map and the optional anti-ghost logic.

## Test plan
- Bytes `1C`, then `F0 1C` 10 cycles later: `left` = `01` from the cycle after `1C` until the cycle after the final `1C`, then `00`.
- `E0 74` back-to-back, then `E0 F0 74`: `right` = `10`, then `00`; `left`, `jump` and `stay` stay `00` throughout.
- `F0` followed by no byte for `TIMEOUT_CYCLES` clocks, then `1D`: FSM in `IDLE` before `1D` arrives; `jump` = `01`, so the `1D` is treated as a make, not a break.
- Hold A and Right arrow; assert `rst` for 3 cycles mid-sequence after an `E0`: all outputs `00` asynchronously. A subsequent `1B` gives `stay` = `01`.
- With `KEY_ANTIGHOST_EN`, `23` then `1C`: `right` = `00`, `left` = `01`. Then `F0 1C`: `right` = `01`. Without the macro, the same stimulus gives `left` = `01` and `right` = `01` simultaneously.
